// File: rtl/fft32_stage_ctrl.sv
// Radix-2 DIT FFT sequencer: walks LOG2N stages x N/2 butterflies, one butterfly per MEM_LATENCY+1 cycles.
// No backpressure: start is accepted only in IDLE, then the run proceeds at a fixed rate until done.
module fft32_stage_ctrl #(
  parameter int LOG2N       = 5,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr0,
  output logic [LOG2N-1:0] rd_addr1,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr0,
  output logic [LOG2N-1:0] wr_addr1,
  output logic [2:0]       stage
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

  localparam logic [2:0]       LAST_STAGE = 3'(LOG2N - 1);
  localparam logic [7:0]       WAIT_LAST  = 8'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);
  localparam logic [LOG2N-1:0] ONE        = 1;
  localparam logic [LOG2N-2:0] B_ONE      = 1;

  state_t           state;
  logic [2:0]       s_cnt;
  logic [LOG2N-2:0] b_cnt;
  logic [7:0]       wait_cnt;

  logic             last_bfly;
  logic             issue;
  logic [2:0]       iss_s;
  logic [LOG2N-2:0] iss_b;
  logic [LOG2N-1:0] b_ext;
  logic [LOG2N-1:0] lo_mask;
  logic [LOG2N-2:0] pos;
  logic [LOG2N-1:0] iss_a0;
  logic [LOG2N-1:0] iss_a1;
  logic [LOG2N-2:0] iss_tw;

  // Addresses of the butterfly about to be read: the first one from IDLE, otherwise the successor.
  always_comb begin
    last_bfly = (s_cnt == LAST_STAGE) && (&b_cnt);
    issue     = ((state == S_IDLE) && start) || ((state == S_WRITE) && !last_bfly);
    if (state == S_IDLE) begin
      iss_s = '0;
      iss_b = '0;
    end else begin
      iss_b = b_cnt + B_ONE;
      iss_s = (&b_cnt) ? s_cnt + 3'd1 : s_cnt;
    end
    b_ext   = {1'b0, iss_b};
    lo_mask = ~({LOG2N{1'b1}} << iss_s);
    // grp*2h + pos == (b with its low s bits kept, high bits shifted up by one)
    iss_a0  = ((b_ext & ~lo_mask) << 1) | (b_ext & lo_mask);
    iss_a1  = iss_a0 | (ONE << iss_s);
    pos     = iss_b & lo_mask[LOG2N-2:0];
    iss_tw  = pos << (LAST_STAGE - iss_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      s_cnt    <= '0;
      b_cnt    <= '0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      wr_en    <= 1'b0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
      wr_addr0 <= '0;
      wr_addr1 <= '0;
      tw_addr  <= '0;
      stage    <= '0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_READ;
            busy  <= 1'b1;
            rd_en <= 1'b1;
          end
        end
        S_READ: begin
          if (MEM_LATENCY == 1) begin
            state <= S_WRITE;
            wr_en <= 1'b1;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= S_WRITE;
            wr_en <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WRITE: begin
          if (last_bfly) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_READ;
            rd_en <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Write addresses and twiddle are captured with the read so they hold steady until WRITE ends.
      if (issue) begin
        s_cnt    <= iss_s;
        b_cnt    <= iss_b;
        stage    <= iss_s;
        rd_addr0 <= iss_a0;
        rd_addr1 <= iss_a1;
        wr_addr0 <= iss_a0;
        wr_addr1 <= iss_a1;
        tw_addr  <= iss_tw;
      end
    end
  end

  a_no_rd_wr_overlap: assert property (@(posedge clk) disable iff (rst) !(rd_en && wr_en));
  a_done_not_busy:    assert property (@(posedge clk) disable iff (rst) !(done && busy));

endmodule

// File: tb/tb_fft32_stage_ctrl.sv
// Directed bench for fft32_stage_ctrl: address table, run timing, start handling, reset and impulse FFT.
module tb_fft32_stage_ctrl;
  localparam int  NB    = 80;
  localparam int  LOGSZ = 1024;
  localparam real AMP   = 8.0;
  localparam real PI    = 3.14159265358979;

  logic clk = 1'b0, rst = 1'b0, start_1 = 1'b0, start_3 = 1'b0, ram_load = 1'b0;

  logic       busy_1, done_1, rd_en_1, wr_en_1;
  logic [4:0] rd_addr0_1, rd_addr1_1, wr_addr0_1, wr_addr1_1;
  logic [3:0] tw_addr_1;
  logic [2:0] stage_1;
  logic       busy_3, done_3, rd_en_3, wr_en_3;
  logic [4:0] rd_addr0_3, rd_addr1_3, wr_addr0_3, wr_addr1_3;
  logic [3:0] tw_addr_3;
  logic [2:0] stage_3;

  fft32_stage_ctrl #(.LOG2N(5), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_1), .busy(busy_1), .done(done_1),
    .rd_en(rd_en_1), .rd_addr0(rd_addr0_1), .rd_addr1(rd_addr1_1), .tw_addr(tw_addr_1),
    .wr_en(wr_en_1), .wr_addr0(wr_addr0_1), .wr_addr1(wr_addr1_1), .stage(stage_1));

  fft32_stage_ctrl #(.LOG2N(5), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start_3), .busy(busy_3), .done(done_3),
    .rd_en(rd_en_3), .rd_addr0(rd_addr0_3), .rd_addr1(rd_addr1_3), .tw_addr(tw_addr_3),
    .wr_en(wr_en_3), .wr_addr0(wr_addr0_3), .wr_addr1(wr_addr1_3), .stage(stage_3));

  always #5 clk = ~clk;

  int exp_s [0:NB-1];
  int exp_a0[0:NB-1];
  int exp_a1[0:NB-1];
  int exp_tw[0:NB-1];

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- monitors (sample on the falling edge) ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_cnt = 0, wr_cnt = 0, busy_cnt1 = 0, done_cnt1 = 0, done_cyc1 = 0, overlap1 = 0;
  logic [2:0] log_s  [0:LOGSZ-1];
  logic [4:0] log_a0 [0:LOGSZ-1];
  logic [4:0] log_a1 [0:LOGSZ-1];
  logic [3:0] log_tw [0:LOGSZ-1];
  logic [4:0] log_w0 [0:LOGSZ-1];
  logic [4:0] log_w1 [0:LOGSZ-1];
  logic [3:0] log_wtw[0:LOGSZ-1];
  int         log_rc [0:LOGSZ-1];
  int         log_wc [0:LOGSZ-1];

  always @(negedge clk) begin
    if (rd_en_1) begin
      if (rd_cnt < LOGSZ) begin
        log_s[rd_cnt]  = stage_1;
        log_a0[rd_cnt] = rd_addr0_1;
        log_a1[rd_cnt] = rd_addr1_1;
        log_tw[rd_cnt] = tw_addr_1;
        log_rc[rd_cnt] = cyc;
      end
      rd_cnt++;
    end
    if (wr_en_1) begin
      if (wr_cnt < LOGSZ) begin
        log_w0[wr_cnt]  = wr_addr0_1;
        log_w1[wr_cnt]  = wr_addr1_1;
        log_wtw[wr_cnt] = tw_addr_1;
        log_wc[wr_cnt]  = cyc;
      end
      wr_cnt++;
    end
    if (rd_en_1 && wr_en_1) overlap1++;
    if (busy_1) busy_cnt1++;
    if (done_1) begin
      done_cnt1++;
      done_cyc1 = cyc;
    end
  end

  int rd3_cnt = 0, rd3_first = 0, rd3_second = 0, rd3_last = 0, sp_err3 = 0, wr_err3 = 0;
  int addr_err3 = 0, busy3_cnt = 0, done3_cnt = 0, done3_cyc = 0;
  always @(negedge clk) begin
    if (rd_en_3) begin
      if (rd3_cnt == 0) rd3_first = cyc;
      else if (cyc - rd3_last != 4) sp_err3++;
      if (rd3_cnt == 1) rd3_second = cyc;
      if (rd3_cnt < NB && (stage_3 != 3'(exp_s[rd3_cnt]) || rd_addr0_3 != 5'(exp_a0[rd3_cnt]) ||
          rd_addr1_3 != 5'(exp_a1[rd3_cnt]) || tw_addr_3 != 4'(exp_tw[rd3_cnt]))) addr_err3++;
      rd3_last = cyc;
      rd3_cnt++;
    end
    if (wr_en_3) begin
      if (rd3_cnt == 0 || rd3_cnt > NB || cyc - rd3_last != 3) wr_err3++;
      else if (wr_addr0_3 != 5'(exp_a0[rd3_cnt-1]) || wr_addr1_3 != 5'(exp_a1[rd3_cnt-1]) ||
               tw_addr_3 != 4'(exp_tw[rd3_cnt-1])) wr_err3++;
    end
    if (busy_3) busy3_cnt++;
    if (done_3) begin
      done3_cnt++;
      done3_cyc = cyc;
    end
  end

  // ---------------- behavioural RAM + twiddle ROM + butterfly on dut1 ----------------
  real ram_re[0:31];
  real ram_im[0:31];
  real q0_re, q0_im, q1_re, q1_im, w_re, w_im, t_re, t_im;
  always @(negedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 32; i++) begin
        ram_re[i] = (i == 0) ? AMP : 0.0;
        ram_im[i] = 0.0;
      end
    end else begin
      if (rd_en_1) begin
        q0_re = ram_re[rd_addr0_1]; q0_im = ram_im[rd_addr0_1];
        q1_re = ram_re[rd_addr1_1]; q1_im = ram_im[rd_addr1_1];
      end
      if (wr_en_1) begin
        w_re = $cos(2.0 * PI * real'(tw_addr_1) / 32.0);
        w_im = -$sin(2.0 * PI * real'(tw_addr_1) / 32.0);
        t_re = w_re * q1_re - w_im * q1_im;
        t_im = w_re * q1_im + w_im * q1_re;
        ram_re[wr_addr0_1] = q0_re + t_re; ram_im[wr_addr0_1] = q0_im + t_im;
        ram_re[wr_addr1_1] = q0_re - t_re; ram_im[wr_addr1_1] = q0_im - t_im;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ml1"}, {1'b0, busy_1, done_1, rd_en_1, rd_addr0_1, rd_addr1_1, tw_addr_1,
                          wr_en_1, wr_addr0_1, wr_addr1_1, stage_1}, 32'd0);
    check({tag, "_ml3"}, {1'b0, busy_3, done_3, rd_en_3, rd_addr0_3, rd_addr1_3, tw_addr_3,
                          wr_en_3, wr_addr0_3, wr_addr1_3, stage_3}, 32'd0);
  endtask

  task automatic wait_done1(input int base, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt1 == base && n < budget) begin tick(); n++; end
    if (done_cnt1 == base) timeout(name);
  endtask

  task automatic wait_rd1(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (rd_cnt < target && n < budget) begin tick(); n++; end
    if (rd_cnt < target) timeout(name);
  endtask

  task automatic check_run(input int rb, input int wb, input string tag);
    logic [31:0] got, exp;
    for (int k = 0; k < NB; k++) begin
      got = {1'b0, log_s[rb+k], log_a0[rb+k], log_a1[rb+k], log_tw[rb+k],
             log_w0[wb+k], log_w1[wb+k], log_wtw[wb+k]};
      exp = {1'b0, 3'(exp_s[k]), 5'(exp_a0[k]), 5'(exp_a1[k]), 4'(exp_tw[k]),
             5'(exp_a0[k]), 5'(exp_a1[k]), 4'(exp_tw[k])};
      check($sformatf("%s_bfly%0d", tag, k), got, exp);
    end
  endtask

  typedef struct { int idx; int s; int a0; int a1; int tw; } vec_t;
  vec_t vec[0:8];

  int c0, rb, wb, db, bb, d, r0, w0, n;

  initial begin
    vec[0] = '{0, 0, 0, 1, 0};
    vec[1] = '{1, 0, 2, 3, 0};
    vec[2] = '{15, 0, 30, 31, 0};
    vec[3] = '{16, 1, 0, 2, 0};
    vec[4] = '{17, 1, 1, 3, 8};
    vec[5] = '{37, 2, 9, 13, 4};
    vec[6] = '{63, 3, 23, 31, 14};
    vec[7] = '{64, 4, 0, 16, 0};
    vec[8] = '{79, 4, 15, 31, 15};

    for (int k = 0; k < NB; k++) begin
      int s, b, h;
      s = k / 16;
      b = k % 16;
      h = 1 << s;
      exp_s[k]  = s;
      exp_a0[k] = (b / h) * 2 * h + (b % h);
      exp_a1[k] = exp_a0[k] + h;
      exp_tw[k] = (b % h) * (16 >> s);
    end

    // Asynchronous reset between clock edges, then idle without start.
    #3 rst = 1'b1;
    #1 check_zero("reset_async");
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    check_zero("idle_no_start");

    // Run A: MEM_LATENCY=1 with impulse data through the behavioural datapath.
    ram_load = 1'b1; tick(); ram_load = 1'b0;
    rb = rd_cnt; wb = wr_cnt; db = done_cnt1; bb = busy_cnt1; c0 = cyc;
    start_1 = 1'b1; tick(); start_1 = 1'b0;
    wait_done1(db, 400, "A_done_wait");
    tick();
    check("A_first_rd_cyc", log_rc[rb], c0 + 1);
    check("A_first_wr_cyc", log_wc[wb], c0 + 2);
    check("A_second_rd_cyc", log_rc[rb+1], c0 + 3);
    check("A_done_cyc", done_cyc1, c0 + 1 + 160);
    check("A_done_pulses", done_cnt1 - db, 1);
    check("A_busy_cycles", busy_cnt1 - bb, 160);
    check("A_read_count", rd_cnt - rb, NB);
    check("A_write_count", wr_cnt - wb, NB);
    check("A_rd_wr_overlap", overlap1, 0);
    for (int i = 0; i < 9; i++)
      check($sformatf("A_vec_idx%0d", vec[i].idx),
            {15'd0, log_s[rb+vec[i].idx], log_a0[rb+vec[i].idx], log_a1[rb+vec[i].idx], log_tw[rb+vec[i].idx]},
            {15'd0, 3'(vec[i].s), 5'(vec[i].a0), 5'(vec[i].a1), 4'(vec[i].tw)});
    check_run(rb, wb, "A");
    for (int i = 0; i < 32; i++) begin
      check($sformatf("E2E_re%0d_x1000", i), $rtoi(ram_re[i] * 1000.0), $rtoi(AMP * 1000.0));
      check($sformatf("E2E_im%0d_x1000", i), $rtoi(ram_im[i] * 1000.0), 0);
    end

    // Run E: MEM_LATENCY=3 timing.
    c0 = cyc;
    start_3 = 1'b1; tick(); start_3 = 1'b0;
    n = 0;
    while (done3_cnt == 0 && n < 800) begin tick(); n++; end
    if (done3_cnt == 0) timeout("E_done_wait");
    tick();
    check("E_first_rd_cyc", rd3_first, c0 + 1);
    check("E_rd_to_rd", rd3_second - rd3_first, 4);
    check("E_spacing_errors", sp_err3, 0);
    check("E_busy_cycles", busy3_cnt, 320);
    check("E_done_cyc", done3_cyc, c0 + 1 + 320);
    check("E_read_count", rd3_cnt, NB);
    check("E_addr_errors", addr_err3, 0);
    check("E_write_errors", wr_err3, 0);

    // Run B: start re-pulsed at butterflies 0, 40, 79 and during DONE.
    rb = rd_cnt; wb = wr_cnt; db = done_cnt1; bb = busy_cnt1; c0 = cyc;
    start_1 = 1'b1; tick(); tick(); start_1 = 1'b0;
    wait_rd1(rb + 41, 200, "B_b40_wait");
    start_1 = 1'b1; tick(); start_1 = 1'b0;
    wait_rd1(rb + 80, 200, "B_b79_wait");
    start_1 = 1'b1; tick(); start_1 = 1'b0;
    n = 0;
    while (!done_1 && n < 50) begin tick(); n++; end
    if (!done_1) timeout("B_done_wait");
    start_1 = 1'b1; tick(); start_1 = 1'b0;
    repeat (5) tick();
    check("B_done_cyc", done_cyc1, c0 + 1 + 160);
    check("B_busy_cycles", busy_cnt1 - bb, 160);
    check("B_read_count", rd_cnt - rb, NB);
    check("B_done_pulses", done_cnt1 - db, 1);
    check_run(rb, wb, "B");

    // Run C: start held high through DONE launches a second run.
    rb = rd_cnt; wb = wr_cnt; db = done_cnt1; c0 = cyc;
    start_1 = 1'b1;
    wait_done1(db, 400, "C1_done_wait");
    d = done_cyc1;
    wait_rd1(rb + 81, 10, "C2_start_wait");
    start_1 = 1'b0;
    check("C_first_rd_cyc", log_rc[rb], c0 + 1);
    check("C_first_run_len", d - log_rc[rb], 160);
    check("C_restart_cyc", log_rc[rb+80], d + 2);
    wait_done1(db + 1, 400, "C2_done_wait");
    tick();
    check("C_second_run_len", done_cyc1 - log_rc[rb+80], 160);
    check_run(rb, wb, "C1");
    check_run(rb + 80, wb + 80, "C2");

    // Run D: reset at stage 2, then a fresh full run.
    repeat (3) tick();
    rb = rd_cnt; c0 = cyc;
    start_1 = 1'b1; tick(); start_1 = 1'b0;
    n = 0;
    while (stage_1 != 3'd2 && n < 200) begin tick(); n++; end
    if (stage_1 != 3'd2) timeout("D_stage2_wait");
    #2 rst = 1'b1;
    #1 check_zero("D_reset_midrun");
    r0 = rd_cnt; w0 = wr_cnt;
    tick(); tick();
    rst = 1'b0;
    repeat (20) tick();
    check("D_partial_reads", r0 - rb, 33);
    check("D_writes_after_reset", wr_cnt - w0, 0);
    check("D_reads_after_reset", rd_cnt - r0, 0);
    check("D_busy_after_reset", {31'd0, busy_1}, 0);
    rb = rd_cnt; wb = wr_cnt; db = done_cnt1; bb = busy_cnt1; c0 = cyc;
    start_1 = 1'b1; tick(); start_1 = 1'b0;
    wait_done1(db, 400, "D_done_wait");
    tick();
    check("D_done_cyc", done_cyc1, c0 + 1 + 160);
    check("D_busy_cycles", busy_cnt1 - bb, 160);
    check_run(rb, wb, "D");
    check("overlap_total", overlap1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
